// File: rtl/adres_rf_pkg.sv
// Shared types and config-word layout helpers for the ADRES VLIW tile register file.
// Address fields are sized for the largest supported register file; users take the low AW bits.
package adres_rf_pkg;

    localparam int AW_MAX    = 8;
    localparam int CTX_MAX   = 16;
    localparam int CFG_W_MAX = 1 + 3 * AW_MAX;
    localparam int CHAIN_MAX = CTX_MAX * CFG_W_MAX;

    // Layout for the default 8-register file
    localparam int DEF_AW = 3;
    localparam int CFG_W  = 1 + 3 * DEF_AW;

    typedef struct packed {
        logic              wr_en;
        logic [AW_MAX-1:0] wr_addr;
        logic [AW_MAX-1:0] rda_addr;
        logic [AW_MAX-1:0] rdo_addr;
    } rf_cfg_t;

    function automatic int cfg_width(input int aw);
        return 1 + 3 * aw;
    endfunction

    function automatic int rdo_ofs(input int aw);
        return 0 * aw;
    endfunction

    function automatic int rda_ofs(input int aw);
        return aw;
    endfunction

    function automatic int wr_addr_ofs(input int aw);
        return 2 * aw;
    endfunction

    function automatic int wr_en_ofs(input int aw);
        return 3 * aw;
    endfunction

    function automatic rf_cfg_t cfg_slice(input logic [CHAIN_MAX-1:0] chain,
                                          input int                   ctx,
                                          input int                   aw);
        logic [CHAIN_MAX-1:0] word;
        logic [CHAIN_MAX-1:0] en_bits;
        logic [AW_MAX-1:0]    amask;
        rf_cfg_t              f;
        word     = chain >> (ctx * cfg_width(aw));
        amask    = AW_MAX'((32'd1 << aw) - 32'd1);
        en_bits  = word >> wr_en_ofs(aw);
        f.wr_en    = en_bits[0];
        f.wr_addr  = AW_MAX'(word >> wr_addr_ofs(aw)) & amask;
        f.rda_addr = AW_MAX'(word >> rda_ofs(aw)) & amask;
        f.rdo_addr = AW_MAX'(word >> rdo_ofs(aw)) & amask;
        return f;
    endfunction

endpackage

// File: rtl/adres_rf_config_chain.sv
// Serial configuration shift chain (one word per schedule context) and the
// word select for the context currently being executed.
module adres_rf_config_chain
    import adres_rf_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int NUM_CONTEXTS = 4
) (
    input  logic                                                     CGRA_Clock,
    input  logic                                                     CGRA_Reset,
    input  logic                                                     ConfigLoad,
    input  logic                                                     ConfigIn,
    input  logic [$clog2(NUM_CONTEXTS > 1 ? NUM_CONTEXTS : 2)-1:0]  ctx,
    output rf_cfg_t                                                  cur_cfg,
    output logic                                                     ConfigOut
);

    localparam int AW      = $clog2(NUM_REGS);
    localparam int CHAIN_W = NUM_CONTEXTS * (1 + 3 * AW);

    logic [CHAIN_W-1:0] chain;

    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            chain <= '0;
        end else if (ConfigLoad) begin
            chain <= {chain[CHAIN_W-2:0], ConfigIn};
        end
    end

    assign ConfigOut = chain[CHAIN_W-1];

    // Reads stay live while loading, so the select tracks the partial chain.
    assign cur_cfg = cfg_slice(CHAIN_MAX'(chain), 32'(ctx), AW);

endmodule

// File: rtl/adres_vliw_regfile.sv
// Multi-context local register file for one ADRES VLIW FU tile.
// Optional write-through forwarding: define ADRES_RF_WRITE_BYPASS_EN.
module adres_vliw_regfile
    import adres_rf_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 8,
    parameter int NUM_CONTEXTS = 4
) (
    input  logic                                                     CGRA_Clock,
    input  logic                                                     CGRA_Reset,
    input  logic                                                     CGRA_Enable,
    input  logic                                                     ConfigLoad,
    input  logic                                                     ConfigIn,
    output logic                                                     ConfigOut,
    input  logic [DATA_WIDTH-1:0]                                    fu_to_rf,
    output logic [DATA_WIDTH-1:0]                                    rf_to_muxa,
    output logic [DATA_WIDTH-1:0]                                    rf_to_muxout,
    output logic [$clog2(NUM_CONTEXTS > 1 ? NUM_CONTEXTS : 2)-1:0]  context_idx
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_CONTEXTS > 1 ? NUM_CONTEXTS : 2);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [CW-1:0]         ctx_q;
    rf_cfg_t               cur_cfg;
    logic [AW-1:0]         wa;
    logic [AW-1:0]         ra;
    logic [AW-1:0]         ro;
    logic                  wr_fire;
    logic                  step_en;
    logic                  unused_cfg;

    adres_rf_config_chain #(
        .NUM_REGS     (NUM_REGS),
        .NUM_CONTEXTS (NUM_CONTEXTS)
    ) u_cfg_chain (
        .CGRA_Clock (CGRA_Clock),
        .CGRA_Reset (CGRA_Reset),
        .ConfigLoad (ConfigLoad),
        .ConfigIn   (ConfigIn),
        .ctx        (ctx_q),
        .cur_cfg    (cur_cfg),
        .ConfigOut  (ConfigOut)
    );

    assign wa         = cur_cfg.wr_addr[AW-1:0];
    assign ra         = cur_cfg.rda_addr[AW-1:0];
    assign ro         = cur_cfg.rdo_addr[AW-1:0];
    assign unused_cfg = ^cur_cfg;

    assign step_en = CGRA_Enable & ~ConfigLoad;
    assign wr_fire = step_en & cur_cfg.wr_en;

    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            ctx_q <= '0;
        end else if (step_en) begin
            ctx_q <= (ctx_q == CW'(NUM_CONTEXTS - 1)) ? '0 : ctx_q + 1'b1;
        end
    end

    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wa] <= fu_to_rf;
        end
    end

`ifdef ADRES_RF_WRITE_BYPASS_EN
    // Forwarding can close a loop through the FU and mux A; configs must avoid it.
    assign rf_to_muxa   = (wr_fire && (wa == ra)) ? fu_to_rf : regs[ra];
    assign rf_to_muxout = (wr_fire && (wa == ro)) ? fu_to_rf : regs[ro];
`else
    assign rf_to_muxa   = regs[ra];
    assign rf_to_muxout = regs[ro];
`endif

    assign context_idx = ctx_q;

endmodule
